metadata_check: RTL and testbench
=================================

METADATA_CHECK -- requirements
Module: metadata_check

Interface
REQ-001 The block SHALL have parameter CHECK_PAD, default 1, meaning padding-zero check enabled (0 = err_pad never asserts).
REQ-002 The block SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port MD_FIXED  input  512  expected fixed metadata field, big-endian, quasi-static.
REQ-005 The block SHALL have port clear_err  input  1  one-cycle pulse clearing sticky error flags and error counter.
REQ-006 The block SHALL have port AXIS_MD_TDATA  input  512  metadata stream data, two beats per set, no TLAST.
REQ-007 The block SHALL have port AXIS_MD_TVALID  input  1  stream valid.
REQ-008 The block SHALL have port AXIS_MD_TREADY  output  1  stream ready, registered.
REQ-009 The block SHALL have port md_valid  output  1  one-cycle pulse, one set checked.
REQ-010 The block SHALL have port md_seq  output  64  sequence number of the last checked set.
REQ-011 The block SHALL have port sets_rcvd  output  64  count of complete sets received.
REQ-012 The block SHALL have port err_seq, err_fixed, err_pad  output  1 each  sticky error flags.
REQ-013 The block SHALL have port err_count  output  32  number of sets with at least one error, saturating.

Function
REQ-014 A beat SHALL be accepted on a cycle with AXIS_MD_TVALID=1 and AXIS_MD_TREADY=1.
REQ-015 AXIS_MD_TREADY SHALL be 0 in the first cycle after resetn rises, then 1 continuously.
REQ-016 The FSM SHALL have states B0 (await first beat) and B1 (await second beat); B0->B1 on acceptance, B1->B0 on acceptance, no other transitions.
REQ-017 In B0 an accepted beat SHALL be registered as beat0; in B1 the accepted beat is beat1, and the set word is W = {beat1, beat0} (1024 bits).
REQ-018 The received sequence number SHALL be W[63:0], little-endian as transmitted, with no swap.
REQ-019 The fixed-field check SHALL compare W[575:64] with MD_FIXED byte-reversed across 64 bytes (MD_FIXED[7:0] at W[575:568], MD_FIXED[511:504] at W[71:64]).
REQ-020 The padding check SHALL require W[1023:576] == 0 when CHECK_PAD=1.
REQ-021 An expected-sequence register SHALL reset to 1; each set SHALL flag a sequence error if the received value differs from it.
REQ-022 After each set the expected-sequence register SHALL load (received+1) mod 2^64, resynchronising after a mismatch; wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 SHALL be legal.
REQ-023 Results SHALL be registered one cycle after beat1 acceptance: md_valid=1 for exactly one cycle, md_seq=received, sets_rcvd+1 (wraps mod 2^64), error flags OR-set, err_count+1 if any error.
REQ-024 err_count SHALL saturate at 0xFFFF_FFFF.
REQ-025 If clear_err coincides with a result cycle, that set's errors SHALL be retained (clear first, then set); err_count becomes 1 if that set erred, else 0.
REQ-026 Back-to-back sets with no idle cycles SHALL be accepted at full rate (one beat per cycle), each producing one md_valid.
REQ-027 TVALID gaps between beat0 and beat1 SHALL be tolerated indefinitely, with beat0 held.

Reset
REQ-028 While resetn=0, outputs SHALL be: AXIS_MD_TREADY=0, md_valid=0, md_seq=0, sets_rcvd=0, all err_* flags=0, err_count=0; FSM=B0; expected sequence=1.
REQ-029 Reset asserted in state B1 SHALL discard the held beat0 with no md_valid; the next accepted beat after reset is beat0.

Verification
REQ-030 Bench SHALL drive three correct sets, seq 1,2,3, MD_FIXED=0x0102..40 (bytes 1..64), zero pad -> three md_valid pulses, md_seq 1,2,3, sets_rcvd=3, no error flags, err_count=0.
REQ-031 Bench SHALL drive seq 1,2,5,6 -> err_seq set on the third set only, err_count=1, fourth set clean (resync).
REQ-032 Bench SHALL flip one bit of W[575:64] in set 2, then one bit of W[600] in set 3 -> err_fixed after set 2, err_pad after set 3, err_count=2; with CHECK_PAD=0 -> err_pad stays 0 and err_count=1.
REQ-033 Bench SHALL drive beat0, deassert TVALID 10 cycles, then beat1 -> exactly one md_valid, 1 cycle after beat1 accept; separately, back-to-back 8 sets with TVALID always 1 -> 8 md_valid pulses in 16+1 cycles.
REQ-034 Bench SHALL apply resetn=0 for 1 cycle after beat0 only, then send a full correct set with seq 1 -> no error, md_seq=1, sets_rcvd=1.
REQ-035 Bench SHALL drive seq 0xFFFF_FFFF_FFFF_FFFF after preloading via a mismatching set, followed by seq 0 -> no err_seq on the seq-0 set; clear_err coincident with an erroneous set leaves err_count=1.

Source files
------------

// File: rtl/metadata_check.sv
// rtl/metadata_check.sv - two-beat metadata set receiver with sequence, fixed-field and padding checks
module metadata_check #(
  parameter int CHECK_PAD = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [511:0] MD_FIXED,
  input  logic         clear_err,
  input  logic [511:0] AXIS_MD_TDATA,
  input  logic         AXIS_MD_TVALID,
  output logic         AXIS_MD_TREADY,
  output logic         md_valid,
  output logic [63:0]  md_seq,
  output logic [63:0]  sets_rcvd,
  output logic         err_seq,
  output logic         err_fixed,
  output logic         err_pad,
  output logic [31:0]  err_count
);

  typedef enum logic {B0, B1} state_t;

  state_t         state, state_nxt;
  logic           accept;
  logic           set_done;
  logic [511:0]   beat0;
  logic [63:0]    exp_seq;
  logic [1023:0]  w;
  logic [511:0]   fixed_exp;
  logic [63:0]    rx_seq;
  logic           bad_seq, bad_fixed, bad_pad, any_err;
  logic           err_seq_nxt, err_fixed_nxt, err_pad_nxt;
  logic [31:0]    cnt_base, cnt_nxt;

  assign accept = AXIS_MD_TVALID & AXIS_MD_TREADY;

  always_ff @(posedge clk) begin
    if (!resetn) state <= B0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    case (state)
      B0: if (accept) state_nxt = B1;
      B1: if (accept) begin
        state_nxt = B0;
        set_done  = 1'b1;
      end
      default: state_nxt = B0;
    endcase
  end

  // Set word is only meaningful on the beat1 acceptance cycle.
  assign w      = {AXIS_MD_TDATA, beat0};
  assign rx_seq = w[63:0];

  // The fixed field travels in ascending byte order, so MD_FIXED's MSB byte lands lowest.
  always_comb begin
    fixed_exp = '0;
    for (int i = 0; i < 64; i++)
      fixed_exp[8*i +: 8] = MD_FIXED[511-8*i -: 8];
  end

  assign bad_seq   = (rx_seq != exp_seq);
  assign bad_fixed = (w[575:64] != fixed_exp);
  assign bad_pad   = (CHECK_PAD != 0) && (|w[1023:576]);
  assign any_err   = bad_seq | bad_fixed | bad_pad;

  // clear_err is applied before the current set's errors so they survive a coincident clear.
  always_comb begin
    err_seq_nxt   = clear_err ? 1'b0 : err_seq;
    err_fixed_nxt = clear_err ? 1'b0 : err_fixed;
    err_pad_nxt   = clear_err ? 1'b0 : err_pad;
    cnt_base      = clear_err ? 32'd0 : err_count;
    cnt_nxt       = cnt_base;
    if (set_done) begin
      err_seq_nxt   = err_seq_nxt   | bad_seq;
      err_fixed_nxt = err_fixed_nxt | bad_fixed;
      err_pad_nxt   = err_pad_nxt   | bad_pad;
      if (any_err && (cnt_base != 32'hFFFF_FFFF))
        cnt_nxt = cnt_base + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      AXIS_MD_TREADY <= 1'b0;
      md_valid       <= 1'b0;
      md_seq         <= '0;
      sets_rcvd      <= '0;
      exp_seq        <= 64'd1;
      beat0          <= '0;
      err_seq        <= 1'b0;
      err_fixed      <= 1'b0;
      err_pad        <= 1'b0;
      err_count      <= '0;
    end else begin
      AXIS_MD_TREADY <= 1'b1;
      md_valid       <= set_done;
      err_seq        <= err_seq_nxt;
      err_fixed      <= err_fixed_nxt;
      err_pad        <= err_pad_nxt;
      err_count      <= cnt_nxt;
      if (state == B0 && accept)
        beat0 <= AXIS_MD_TDATA;
      if (set_done) begin
        md_seq    <= rx_seq;
        sets_rcvd <= sets_rcvd + 64'd1;
        exp_seq   <= rx_seq + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_metadata_check.sv
// tb/tb_metadata_check.sv - randomized and directed self-checking bench for metadata_check
module tb_metadata_check;

  logic         clk = 1'b0;
  logic         resetn;
  logic [511:0] md_fixed;
  logic         clear_err;
  logic [511:0] tdata;
  logic         tvalid;

  logic         tready, md_valid, err_seq, err_fixed, err_pad;
  logic [63:0]  md_seq, sets_rcvd;
  logic [31:0]  err_count;

  logic         tready_np, md_valid_np, err_seq_np, err_fixed_np, err_pad_np;
  logic [63:0]  md_seq_np, sets_rcvd_np;
  logic [31:0]  err_count_np;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [63:0] m_exp, m_last, m_sets;
  logic        m_eseq, m_efix, m_epad;
  logic [31:0] m_cnt, m_cnt_np;

  always #5 clk = ~clk;

  metadata_check #(.CHECK_PAD(1)) dut (
    .clk(clk), .resetn(resetn), .MD_FIXED(md_fixed), .clear_err(clear_err),
    .AXIS_MD_TDATA(tdata), .AXIS_MD_TVALID(tvalid), .AXIS_MD_TREADY(tready),
    .md_valid(md_valid), .md_seq(md_seq), .sets_rcvd(sets_rcvd),
    .err_seq(err_seq), .err_fixed(err_fixed), .err_pad(err_pad), .err_count(err_count)
  );

  metadata_check #(.CHECK_PAD(0)) dut_np (
    .clk(clk), .resetn(resetn), .MD_FIXED(md_fixed), .clear_err(clear_err),
    .AXIS_MD_TDATA(tdata), .AXIS_MD_TVALID(tvalid), .AXIS_MD_TREADY(tready_np),
    .md_valid(md_valid_np), .md_seq(md_seq_np), .sets_rcvd(sets_rcvd_np),
    .err_seq(err_seq_np), .err_fixed(err_fixed_np), .err_pad(err_pad_np), .err_count(err_count_np)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed byte k (k=0 is the MSB byte of MD_FIXED) occupies set-word byte k+8.
  function automatic logic [1023:0] build_w(input logic [63:0] seq, input int fbit, input int pbit);
    logic [1023:0] w;
    logic [7:0]    fb;
    w = '0;
    w[63:0] = seq;
    for (int k = 0; k < 64; k++) begin
      fb = md_fixed[511-8*k -: 8];
      w[8*(k+8) +: 8] = fb;
    end
    if (fbit >= 0) w[fbit] = ~w[fbit];
    if (pbit >= 0) w[pbit] = ~w[pbit];
    return w;
  endfunction

  task automatic model_reset();
    m_exp = 64'd1; m_last = '0; m_sets = '0;
    m_eseq = 0; m_efix = 0; m_epad = 0; m_cnt = '0; m_cnt_np = '0;
  endtask

  task automatic model_set(input logic [63:0] seq, input bit fbad, input bit pbad, input bit clr);
    bit sbad;
    sbad = (seq != m_exp);
    m_exp  = seq + 64'd1;
    m_last = seq;
    m_sets = m_sets + 64'd1;
    if (clr) begin
      m_eseq = 0; m_efix = 0; m_epad = 0; m_cnt = '0; m_cnt_np = '0;
    end
    m_eseq = m_eseq | sbad;
    m_efix = m_efix | fbad;
    m_epad = m_epad | pbad;
    if ((sbad || fbad || pbad) && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if ((sbad || fbad) && m_cnt_np != 32'hFFFF_FFFF) m_cnt_np++;
  endtask

  task automatic check_all(input bit v);
    chk("md_valid", md_valid, v);
    chk("md_seq", md_seq, m_last);
    chk("sets_rcvd", sets_rcvd, m_sets);
    chk("err_seq", err_seq, m_eseq);
    chk("err_fixed", err_fixed, m_efix);
    chk("err_pad", err_pad, m_epad);
    chk("err_count", err_count, m_cnt);
    chk("np_md_valid", md_valid_np, v);
    chk("np_err_fixed", err_fixed_np, m_efix);
    chk("np_err_pad", err_pad_np, 0);
    chk("np_err_count", err_count_np, m_cnt_np);
  endtask

  task automatic do_reset();
    resetn = 1'b0; tvalid = 1'b0; clear_err = 1'b0;
    tick();
    model_reset();
    chk("rst_tready", tready, 0);
    check_all(0);
    resetn = 1'b1;
    #1;
    chk("tready_first_cycle", tready, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 4 && tready !== 1'b1; i++) tick();
    chk("tready_up", tready, 1);
  endtask

  task automatic send_set(input logic [63:0] seq, input int fbit, input int pbit,
                          input int gap, input bit clr);
    logic [1023:0] w;
    w = build_w(seq, fbit, pbit);
    wait_ready();
    tdata = w[511:0]; tvalid = 1'b1;
    tick();
    check_all(0);
    if (gap > 0) begin
      tvalid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check_all(0);
      end
    end
    tdata = w[1023:512]; tvalid = 1'b1; clear_err = clr;
    tick();
    tvalid = 1'b0; clear_err = 1'b0;
    model_set(seq, fbit >= 0, pbit >= 0, clr);
    check_all(1);
    tick();
    check_all(0);
  endtask

  initial begin
    logic [1023:0] w;
    logic [63:0]   s;
    int            pulses;
    int            fb, pb;

    resetn = 1'b0; clear_err = 1'b0; tvalid = 1'b0; tdata = '0;
    for (int k = 0; k < 64; k++) md_fixed[511-8*k -: 8] = 8'(k + 1);
    tick();

    // reset state, then three clean sets
    do_reset();
    tick();
    send_set(64'd1, -1, -1, 0, 0);
    send_set(64'd2, -1, -1, 0, 0);
    send_set(64'd3, -1, -1, 0, 0);
    chk("clean_sets", sets_rcvd, 3);

    // sequence jump and resync
    do_reset();
    send_set(64'd1, -1, -1, 0, 0);
    send_set(64'd2, -1, -1, 0, 0);
    chk("seq_before_jump", err_seq, 0);
    send_set(64'd5, -1, -1, 0, 0);
    send_set(64'd6, -1, -1, 0, 0);
    chk("seq_jump_count", err_count, 1);

    // fixed-field and padding corruption
    do_reset();
    send_set(64'd1, -1, -1, 0, 0);
    send_set(64'd2, $urandom_range(64, 575), -1, 0, 0);
    chk("fixed_flag", err_fixed, 1);
    send_set(64'd3, -1, 600, 0, 0);
    chk("pad_count", err_count, 2);
    chk("np_pad_count", err_count_np, 1);

    // long TVALID gap between beats
    do_reset();
    send_set(64'd1, -1, -1, 10, 0);

    // eight back-to-back sets at full rate
    wait_ready();
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      s = m_exp;
      w = build_w(s, -1, -1);
      tdata = w[511:0]; tvalid = 1'b1;
      tick();
      check_all(0);
      tdata = w[1023:512];
      tick();
      model_set(s, 0, 0, 0);
      check_all(1);
      if (md_valid === 1'b1) pulses++;
    end
    tvalid = 1'b0;
    tick();
    check_all(0);
    chk("b2b_pulses", pulses, 8);

    // reset while holding beat0 discards it
    w = build_w(64'd42, -1, -1);
    tdata = w[511:0]; tvalid = 1'b1;
    tick();
    do_reset();
    send_set(64'd1, -1, -1, 0, 0);
    chk("post_rst_seq", md_seq, 1);

    // 64-bit wrap after a mismatching preload, then clear coincident with an error
    send_set(64'hFFFF_FFFF_FFFF_FFFE, -1, -1, 0, 0);
    send_set(64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 0, 0);
    send_set(64'd0, -1, -1, 0, 0);
    chk("wrap_count", err_count, 1);
    send_set(64'd77, -1, -1, 0, 1);
    chk("clear_coincident", err_count, 1);

    // randomized sets against the model
    for (int k = 0; k < 64; k++) md_fixed[8*k +: 8] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 40; n++) begin
      s  = ($urandom_range(0, 4) == 0) ? {32'($urandom), 32'($urandom)} : m_exp;
      fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(64, 575)) : -1;
      pb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(576, 1023)) : -1;
      send_set(s, fb, pb, int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
